calc_seq_core: RTL and testbench

Clocked, parametrised successor to the combinational calculator datapath. It accepts decimal operands entered one digit at a time from one-hot keys and computes add, multiply, subtract or divide with multi-cycle sequential units. It converts the magnitude to packed BCD internally, then presents result, sign, error and BCD together on a one-cycle `done` strobe. It sits between the key/switch input logic and the 7-segment display drivers.

---
 rtl/calc_pkg.sv | 23 ++
 rtl/calc_bin2bcd.sv | 62 ++++++
 rtl/calc_seq_core.sv | 167 ++++++++++++++++
 tb/tb_calc_seq_core.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the sequential calculator datapath.
// Holds the op encodings, FSM state type and key-decoding helper.
package calc_pkg;

    localparam int unsigned BCD_W = 4;

    localparam logic [3:0] MODE_ADD = 4'b0001;
    localparam logic [3:0] MODE_MUL = 4'b0010;
    localparam logic [3:0] MODE_SUB = 4'b0100;
    localparam logic [3:0] MODE_DIV = 4'b1000;

    typedef enum logic [1:0] {StIdle, StCalc, StConv, StDone} calc_state_t;

    function automatic logic [3:0] key_digit(input logic [9:0] k);
        logic [3:0] d;
        d = '0;
        for (int i = 0; i < 10; i++) begin
            if (k[i]) d = 4'(i);
        end
        return d;
    endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter with a load/done handshake.
// The first bit is shifted in on the load cycle, so conversion spans WIDTH cycles.
module calc_bin2bcd
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [WIDTH-1:0]          value,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   bcd
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0]        shreg;
    logic [CNT_W-1:0]        cnt;
    logic                    running;
    logic [BCD_W*DIGITS-1:0] adj;
    logic [BCD_W*DIGITS-1:0] step;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[i*BCD_W +: BCD_W] >= 4'd5) begin
                adj[i*BCD_W +: BCD_W] = adj[i*BCD_W +: BCD_W] + 4'd3;
            end
        end
        step = {adj[BCD_W*DIGITS-2:0], shreg[WIDTH-1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                // Digits start at zero, so the first step needs no adjust.
                bcd     <= {{(BCD_W*DIGITS-1){1'b0}}, value[WIDTH-1]};
                shreg   <= value << 1;
                cnt     <= CNT_W'(WIDTH-1);
                running <= 1'b1;
            end else if (running) begin
                bcd   <= step;
                shreg <= shreg << 1;
                cnt   <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/calc_seq_core.sv
// Clocked calculator: digit entry, multi-cycle add/sub/mul/div, then BCD conversion.
// Result, sign, error and BCD are presented together with a one-cycle done strobe.
module calc_seq_core
    import calc_pkg::*;
#(
    parameter int unsigned OPW        = 8,
    parameter int unsigned RES_DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [9:0]                key,
    input  logic                      key_valid,
    input  logic                      sel_b,
    input  logic                      clr_entry,
    input  logic [3:0]                mode,
    input  logic                      start,
    output logic [OPW-1:0]            a,
    output logic [OPW-1:0]            b,
    output logic                      busy,
    output logic                      done,
    output logic [2*OPW-1:0]          result,
    output logic                      neg,
    output logic                      err,
    output logic [BCD_W*RES_DIGITS-1:0] bcd
);

    localparam int unsigned EW    = OPW + 4;
    localparam int unsigned CNT_W = $clog2(OPW);

    calc_state_t             state;
    logic [OPW-1:0]          op_a, op_b;
    logic [3:0]              mode_q;
    logic [2*OPW-1:0]        work;
    logic                    neg_calc;
    logic [CNT_W-1:0]        cnt;

    logic [OPW-1:0]          cur_op;
    logic                    key_ok, entry_fits;
    logic [EW-1:0]           entry_val;
    logic [OPW:0]            mul_sum, div_rem_sh, div_diff;
    logic                    div_ge;
    logic [2*OPW-1:0]        mul_next, div_next, iter_next, calc_value;
    logic                    is_iter, mode_bad, calc_bad, calc_last;
    logic                    conv_load, conv_done;
    logic [BCD_W*RES_DIGITS-1:0] conv_bcd;

    always_comb begin
        cur_op     = sel_b ? b : a;
        key_ok     = (key != '0) && ((key & (key - 10'd1)) == '0);
        entry_val  = EW'(cur_op) * EW'(10) + EW'(key_digit(key));
        entry_fits = (entry_val[EW-1:OPW] == '0);

        // Mul: work = {partial sum, multiplier}; shift right each cycle.
        mul_sum  = {1'b0, work[2*OPW-1:OPW]} + (work[0] ? {1'b0, op_a} : '0);
        mul_next = {mul_sum, work[OPW-1:1]};
        // Div: work = {remainder, dividend/quotient}; shift left each cycle.
        div_rem_sh = {work[2*OPW-1:OPW], work[OPW-1]};
        div_ge     = (div_rem_sh >= {1'b0, op_b});
        div_diff   = div_rem_sh - {1'b0, op_b};
        div_next   = {div_ge ? div_diff[OPW-1:0] : div_rem_sh[OPW-1:0], work[OPW-2:0], div_ge};
        iter_next  = (mode_q == MODE_MUL) ? mul_next : div_next;

        is_iter  = (mode_q == MODE_MUL) || (mode_q == MODE_DIV);
        mode_bad = !(mode_q inside {MODE_ADD, MODE_MUL, MODE_SUB, MODE_DIV});
        calc_bad = (cnt == '0) && (mode_bad || ((mode_q == MODE_DIV) && (op_b == '0)));
        calc_last = !is_iter || (cnt == CNT_W'(OPW-1));

        if (mode_q == MODE_ADD) begin
            calc_value = (2*OPW)'(op_a) + (2*OPW)'(op_b);
        end else if (mode_q == MODE_SUB) begin
            calc_value = (op_b > op_a) ? (2*OPW)'(op_b - op_a) : (2*OPW)'(op_a - op_b);
        end else if (mode_q == MODE_MUL) begin
            calc_value = mul_next;
        end else begin
            calc_value = {{OPW{1'b0}}, div_next[OPW-1:0]};
        end

        conv_load = (state == StCalc) && !calc_bad && calc_last;
    end

    calc_bin2bcd #(
        .WIDTH  (2*OPW),
        .DIGITS (RES_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .load  (conv_load),
        .value (calc_value),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            a        <= '0;
            b        <= '0;
            op_a     <= '0;
            op_b     <= '0;
            mode_q   <= '0;
            work     <= '0;
            neg_calc <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            neg      <= 1'b0;
            err      <= 1'b0;
            bcd      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        op_a     <= a;
                        op_b     <= b;
                        mode_q   <= mode;
                        cnt      <= '0;
                        neg_calc <= 1'b0;
                        work     <= (mode == MODE_MUL) ? (2*OPW)'(b) : (2*OPW)'(a);
                        busy     <= 1'b1;
                        state    <= StCalc;
                    end else if (clr_entry) begin
                        if (sel_b) b <= '0;
                        else       a <= '0;
                    end else if (key_valid && key_ok && entry_fits) begin
                        if (sel_b) b <= entry_val[OPW-1:0];
                        else       a <= entry_val[OPW-1:0];
                    end
                end
                StCalc: begin
                    if (calc_bad) begin
                        err    <= 1'b1;
                        result <= '0;
                        bcd    <= '0;
                        neg    <= 1'b0;
                        done   <= 1'b1;
                        state  <= StDone;
                    end else if (calc_last) begin
                        work     <= calc_value;
                        neg_calc <= (mode_q == MODE_SUB) && (op_b > op_a);
                        state    <= StConv;
                    end else begin
                        work <= iter_next;
                        cnt  <= cnt + 1'b1;
                    end
                end
                StConv: begin
                    if (conv_done) begin
                        result <= work;
                        neg    <= neg_calc;
                        err    <= 1'b0;
                        bcd    <= conv_bcd;
                        done   <= 1'b1;
                        state  <= StDone;
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_seq_core.sv
// Directed self-checking bench for calc_seq_core with hand-computed expectations.
module tb_calc_seq_core;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  key;
    logic        key_valid, sel_b, clr_entry, start;
    logic [3:0]  mode;
    logic [7:0]  a, b;
    logic        busy, done, neg, err;
    logic [15:0] result;
    logic [19:0] bcd;

    int n_checks = 0;
    int n_fail   = 0;

    calc_seq_core #(
        .OPW        (8),
        .RES_DIGITS (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .key_valid (key_valid),
        .sel_b     (sel_b),
        .clr_entry (clr_entry),
        .mode      (mode),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .neg       (neg),
        .err       (err),
        .bcd       (bcd)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic sel, input int d);
        @(negedge clk);
        sel_b     = sel;
        key       = 10'(1 << d);
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key       = '0;
    endtask

    task automatic clear(input logic sel);
        @(negedge clk);
        sel_b     = sel;
        clr_entry = 1'b1;
        @(negedge clk);
        clr_entry = 1'b0;
    endtask

    task automatic enter(input logic sel, input int v);
        clear(sel);
        if (v >= 100) press(sel, v / 100);
        if (v >= 10)  press(sel, (v / 10) % 10);
        press(sel, v % 10);
    endtask

    // Returns at the negedge of cycle 1 (edge 0 sampled start).
    task automatic do_start(input logic [3:0] m);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] m, input int exp_cyc,
                          input logic [15:0] exp_res, input logic exp_neg,
                          input logic exp_err, input logic [19:0] exp_bcd);
        int cyc;
        do_start(m);
        check_eq({tag, "_busy1"}, 32'(busy), 32'd1);
        wait_done(1, cyc);
        check_eq({tag, "_cycle"}, 32'(cyc), 32'(exp_cyc));
        check_eq({tag, "_result"}, 32'(result), 32'(exp_res));
        check_eq({tag, "_neg"}, 32'(neg), 32'(exp_neg));
        check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
        check_eq({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd));
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        int dcount;
        rst = 1'b1; key = '0; key_valid = 1'b0; sel_b = 1'b0;
        clr_entry = 1'b0; mode = '0; start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_a", 32'(a), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_bcd", 32'(bcd), 32'd0);
        rst = 1'b0;

        press(1'b0, 4);
        press(1'b0, 2);
        press(1'b1, 7);
        check_eq("entry_a42", 32'(a), 32'd42);
        check_eq("entry_b7", 32'(b), 32'd7);
        run_op("add", MODE_ADD, 18, 16'd49, 1'b0, 1'b0, 20'h00049);

        enter(1'b0, 3); enter(1'b1, 9);
        run_op("sub_neg", MODE_SUB, 18, 16'd6, 1'b1, 1'b0, 20'h00006);
        enter(1'b0, 9);
        run_op("sub_eq", MODE_SUB, 18, 16'd0, 1'b0, 1'b0, 20'h00000);

        enter(1'b0, 255); enter(1'b1, 255);
        check_eq("entry_a255", 32'(a), 32'd255);
        run_op("mul", MODE_MUL, 25, 16'd65025, 1'b0, 1'b0, 20'h65025);

        enter(1'b0, 200); enter(1'b1, 0);
        run_op("div0", MODE_DIV, 2, 16'd0, 1'b0, 1'b1, 20'h00000);
        enter(1'b1, 7);
        run_op("div", MODE_DIV, 25, 16'd28, 1'b0, 1'b0, 20'h00028);
        run_op("bad_mode", 4'b0011, 2, 16'd0, 1'b0, 1'b1, 20'h00000);

        enter(1'b0, 25);
        press(1'b0, 6);
        check_eq("entry_overflow", 32'(a), 32'd25);
        @(negedge clk);
        sel_b = 1'b0; key = 10'b0000000011; key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0; key = '0;
        check_eq("entry_not_onehot", 32'(a), 32'd25);
        clear(1'b1);
        check_eq("clr_b", 32'(b), 32'd0);
        check_eq("clr_keeps_a", 32'(a), 32'd25);

        // Key strobe and start pulse while busy must have no effect.
        enter(1'b0, 12); enter(1'b1, 3);
        do_start(MODE_ADD);
        sel_b = 1'b0; key = 10'(1 << 5); key_valid = 1'b1; start = 1'b1; mode = MODE_MUL;
        @(negedge clk);
        key_valid = 1'b0; key = '0; start = 1'b0;
        wait_done(2, cyc);
        check_eq("busy_cycle", 32'(cyc), 32'd18);
        check_eq("busy_result", 32'(result), 32'd15);
        check_eq("busy_a_kept", 32'(a), 32'd12);
        dcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check_eq("busy_no_restart", 32'(dcount), 32'd0);

        // Reset during a multiply.
        enter(1'b0, 255); enter(1'b1, 255);
        do_start(MODE_MUL);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_result", 32'(result), 32'd0);
        check_eq("abort_a", 32'(a), 32'd0);
        dcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b0;
            if (done) dcount++;
        end
        check_eq("abort_no_done", 32'(dcount), 32'd0);
        check_eq("abort_bcd", 32'(bcd), 32'd0);
        press(1'b0, 1); press(1'b1, 1);
        run_op("post_rst_add", MODE_ADD, 18, 16'd2, 1'b0, 1'b0, 20'h00002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
